// File: rtl/ul_read_arb.sv
// rtl/ul_read_arb.sv - round-robin arbiter sharing one UL read target between NPORTS initiators
//
// One read in flight at a time: the winning initiator's address is registered
// and forwarded downstream, the returned word is registered and presented only
// to that initiator, and priority rotates once the initiator accepts it.
//
// Ports:
//   s_ul_clk, s_ul_areset        clock, synchronous active-high reset
//   s_ul_araddr/arvalid/arready  packed upstream address channels (port i at [ADDR_WIDTH*i +: ADDR_WIDTH])
//   s_ul_rdata/rvalid/rready     shared registered read data, per-port valid/accept
//   m_ul_araddr/arvalid/arready  downstream address channel (registered)
//   m_ul_rdata/rvalid/rready     downstream data channel
//   grant_id                     index of the current or last granted initiator
//   busy                         high whenever a transaction is in progress

module ul_read_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NPORTS_BITS = 2,
    parameter int NPORTS      = 1 << NPORTS_BITS
) (
    input  logic                         s_ul_clk,
    input  logic                         s_ul_areset,
    input  logic [ADDR_WIDTH*NPORTS-1:0] s_ul_araddr,
    input  logic [NPORTS-1:0]            s_ul_arvalid,
    output logic [NPORTS-1:0]            s_ul_arready,
    output logic [DATA_WIDTH-1:0]        s_ul_rdata,
    output logic [NPORTS-1:0]            s_ul_rvalid,
    input  logic [NPORTS-1:0]            s_ul_rready,
    output logic [ADDR_WIDTH-1:0]        m_ul_araddr,
    output logic                         m_ul_arvalid,
    input  logic                         m_ul_arready,
    input  logic [DATA_WIDTH-1:0]        m_ul_rdata,
    input  logic                         m_ul_rvalid,
    output logic                         m_ul_rready,
    output logic [NPORTS_BITS-1:0]       grant_id,
    output logic                         busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                  state;
    logic [NPORTS_BITS-1:0]  last_grant;
    logic [NPORTS_BITS-1:0]  winner;
    logic                    found;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [NPORTS-1:0]       grant_onehot;

    // Round-robin search starting just after the last grant. NPORTS is a
    // power of two, so the NPORTS_BITS-wide add wraps modulo NPORTS and
    // last_grant itself is the final candidate scanned.
    always_comb begin
        logic [NPORTS_BITS-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = last_grant + NPORTS_BITS'(k);
            if (!found && s_ul_arvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (winner == NPORTS_BITS'(i)) begin
                win_addr = s_ul_araddr[ADDR_WIDTH*i +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        grant_onehot[grant_id] = 1'b1;
    end

    // The only combinational upstream handshake: depends on state and the
    // request vector, never on downstream inputs.
    always_comb begin
        s_ul_arready = '0;
        if (state == ST_IDLE && found) begin
            s_ul_arready[winner] = 1'b1;
        end
    end

    always_ff @(posedge s_ul_clk) begin
        if (s_ul_areset) begin
            state        <= ST_IDLE;
            last_grant   <= '1;
            grant_id     <= '0;
            m_ul_araddr  <= '0;
            m_ul_arvalid <= 1'b0;
            m_ul_rready  <= 1'b0;
            s_ul_rdata   <= '0;
            s_ul_rvalid  <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        m_ul_araddr  <= win_addr;
                        grant_id     <= winner;
                        m_ul_arvalid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_ul_arready) begin
                        m_ul_arvalid <= 1'b0;
                        m_ul_rready  <= 1'b1;
                        state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_ul_rvalid) begin
                        s_ul_rdata  <= m_ul_rdata;
                        m_ul_rready <= 1'b0;
                        s_ul_rvalid <= grant_onehot;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the granted initiator's accept ends the response.
                    if (s_ul_rready[grant_id]) begin
                        s_ul_rvalid <= '0;
                        last_grant  <= grant_id;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ul_read_arb.sv
// tb/tb_ul_read_arb.sv - scoreboard testbench for ul_read_arb

module tb_ul_read_arb;

    logic        clk;
    logic        s_ul_areset;
    logic [15:0] s_ul_araddr;
    logic [3:0]  s_ul_arvalid;
    logic [3:0]  s_ul_arready;
    logic [31:0] s_ul_rdata;
    logic [3:0]  s_ul_rvalid;
    logic [3:0]  s_ul_rready;
    logic [3:0]  m_ul_araddr;
    logic        m_ul_arvalid;
    logic        m_ul_arready;
    logic [31:0] m_ul_rdata;
    logic        m_ul_rvalid;
    logic        m_ul_rready;
    logic [1:0]  grant_id;
    logic        busy;

    ul_read_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NPORTS_BITS(2)) dut (
        .s_ul_clk     (clk),
        .s_ul_areset  (s_ul_areset),
        .s_ul_araddr  (s_ul_araddr),
        .s_ul_arvalid (s_ul_arvalid),
        .s_ul_arready (s_ul_arready),
        .s_ul_rdata   (s_ul_rdata),
        .s_ul_rvalid  (s_ul_rvalid),
        .s_ul_rready  (s_ul_rready),
        .m_ul_araddr  (m_ul_araddr),
        .m_ul_arvalid (m_ul_arvalid),
        .m_ul_arready (m_ul_arready),
        .m_ul_rdata   (m_ul_rdata),
        .m_ul_rvalid  (m_ul_rvalid),
        .m_ul_rready  (m_ul_rready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct { int port; logic [3:0] addr; } req_t;
    typedef struct { int port; logic [31:0] data; } resp_t;

    req_t        req_q[$];
    resp_t       exp_q[$];
    int          exp_grant_q[$];
    logic [31:0] data_tbl[16];

    int n_checks = 0;
    int n_pass   = 0;

    // downstream slave: automatic responder or manual drive from main
    logic        slave_en;
    int          ar_delay, r_delay;
    logic        sl_arready, sl_rvalid, man_arready, man_rvalid;
    logic [31:0] sl_rdata, man_rdata;

    assign m_ul_arready = slave_en ? sl_arready : man_arready;
    assign m_ul_rvalid  = slave_en ? sl_rvalid  : man_rvalid;
    assign m_ul_rdata   = slave_en ? sl_rdata   : man_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h expected none", name, act);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || req_q.size() != 0 || busy) && n < 300);
        if (n >= 300) fail(name, n);
    endtask

    // upstream initiators: each port presents its oldest queued address
    initial begin
        logic [3:0]  hs, av;
        logic [15:0] aa;
        s_ul_arvalid = '0;
        s_ul_araddr  = '0;
        forever begin
            @(negedge clk);
            hs = s_ul_arvalid & s_ul_arready;
            tick();
            for (int p = 0; p < 4; p++) begin
                if (hs[p]) begin
                    for (int j = 0; j < req_q.size(); j++) begin
                        if (req_q[j].port == p) begin
                            req_q.delete(j);
                            break;
                        end
                    end
                end
            end
            av = '0;
            aa = '0;
            for (int p = 0; p < 4; p++) begin
                for (int j = 0; j < req_q.size(); j++) begin
                    if (req_q[j].port == p) begin
                        av[p] = 1'b1;
                        aa[4*p +: 4] = req_q[j].addr;
                        break;
                    end
                end
            end
            s_ul_arvalid = av;
            s_ul_araddr  = aa;
        end
    end

    initial begin
        logic [3:0] la;
        sl_arready = 1'b0;
        sl_rvalid  = 1'b0;
        sl_rdata   = '0;
        forever begin
            tick();
            if (slave_en && m_ul_arvalid) begin
                la = m_ul_araddr;
                repeat (ar_delay) tick();
                sl_arready = 1'b1;
                tick();
                sl_arready = 1'b0;
                repeat (r_delay) tick();
                sl_rvalid = 1'b1;
                sl_rdata  = data_tbl[la];
                tick();
                sl_rvalid = 1'b0;
            end
        end
    end

    // monitor: grants, responses and channel stability
    initial begin
        logic [3:0]  prev_rv;
        logic [31:0] prev_rdata;
        logic [3:0]  prev_maddr;
        logic        prev_mhs, prev_arstall, rise;
        int          gpend, w, e;
        resp_t       r;
        prev_rv = '0; prev_rdata = '0; prev_maddr = '0;
        prev_mhs = 1'b0; prev_arstall = 1'b0; gpend = -1;
        forever begin
            @(negedge clk);
            if (s_ul_areset) begin
                prev_rv = '0; prev_mhs = 1'b0; prev_arstall = 1'b0; gpend = -1;
            end else begin
                if (gpend >= 0) begin
                    check("grant_id", 32'(grant_id), gpend);
                    gpend = -1;
                end
                if (|s_ul_arready) begin
                    w = 0;
                    for (int p = 0; p < 4; p++) if (s_ul_arready[p]) w = p;
                    check("arready_onehot", $countones(s_ul_arready), 1);
                    check("arready_without_arvalid", 32'(s_ul_arready & ~s_ul_arvalid), 0);
                    if (exp_grant_q.size() == 0) fail("grant_unexpected", w);
                    else begin
                        e = exp_grant_q.pop_front();
                        check("grant_port", w, e);
                        gpend = e;
                    end
                end
                if (prev_arstall) begin
                    check("araddr_hold", 32'(m_ul_araddr), 32'(prev_maddr));
                    check("arvalid_hold", 32'(m_ul_arvalid), 1);
                end
                rise = (|s_ul_rvalid) && !(|prev_rv);
                if (rise || prev_mhs) check("rvalid_after_m_hs", 32'(rise), 32'(prev_mhs));
                if (|s_ul_rvalid) begin
                    check("rvalid_onehot", $countones(s_ul_rvalid), 1);
                    if (|prev_rv) check("rdata_hold", s_ul_rdata, prev_rdata);
                    if (|(s_ul_rvalid & s_ul_rready)) begin
                        w = 0;
                        for (int p = 0; p < 4; p++) if (s_ul_rvalid[p]) w = p;
                        if (exp_q.size() == 0) fail("resp_unexpected", s_ul_rdata);
                        else begin
                            r = exp_q.pop_front();
                            check("resp_port", w, r.port);
                            check("resp_data", s_ul_rdata, r.data);
                        end
                    end
                end
                prev_rv      = (|(s_ul_rvalid & s_ul_rready)) ? 4'b0000 : s_ul_rvalid;
                prev_rdata   = s_ul_rdata;
                prev_mhs     = m_ul_rvalid & m_ul_rready;
                prev_arstall = m_ul_arvalid & ~m_ul_arready;
                prev_maddr   = m_ul_araddr;
            end
        end
    end

    task automatic issue(input int port, input logic [3:0] addr, input bit expect_resp);
        req_q.push_back('{port, addr});
        exp_grant_q.push_back(port);
        if (expect_resp) exp_q.push_back('{port, data_tbl[addr]});
    endtask

    initial begin
        int n;
        for (int a = 0; a < 16; a++) data_tbl[a] = 32'(a);
        data_tbl[5] = 32'hCAFEBABE;
        slave_en = 1'b1; ar_delay = 0; r_delay = 0;
        man_arready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        s_ul_rready = 4'b1111;
        s_ul_areset = 1'b1;

        // reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_m_araddr", 32'(m_ul_araddr), 0);
        check("rst_s_rdata", s_ul_rdata, 0);
        check("rst_m_arvalid", 32'(m_ul_arvalid), 0);
        check("rst_m_rready", 32'(m_ul_rready), 0);
        check("rst_s_rvalid", 32'(s_ul_rvalid), 0);
        check("rst_s_arready", 32'(s_ul_arready), 0);
        tick();
        s_ul_areset = 1'b0;
        tick();

        // round robin: all four request, port 0 twice; data = address
        issue(0, 4'h8, 1); issue(1, 4'h9, 1); issue(2, 4'hA, 1);
        issue(3, 4'hB, 1); issue(0, 4'hC, 1);
        drain("rr_drain");

        // single read, cycle-accurate
        issue(2, 4'h5, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ul_arvalid[2] && n < 50);
        if (n >= 50) fail("single_req_timeout", n);
        check("single_c0_arready", 32'(s_ul_arready), 32'h4);
        check("single_c0_busy", 32'(busy), 0);
        @(negedge clk);
        check("single_c1_araddr", 32'(m_ul_araddr), 32'h5);
        check("single_c1_arvalid", 32'(m_ul_arvalid), 1);
        check("single_c1_busy", 32'(busy), 1);
        @(negedge clk);
        check("single_c2_m_rready", 32'(m_ul_rready), 1);
        @(negedge clk);
        check("single_c3_rvalid", 32'(s_ul_rvalid), 32'h4);
        check("single_c3_rdata", s_ul_rdata, 32'hCAFEBABE);
        @(negedge clk);
        check("single_c4_busy", 32'(busy), 0);
        check("single_c4_rvalid", 32'(s_ul_rvalid), 0);
        drain("single_drain");

        // downstream stalls
        ar_delay = 3; r_delay = 5;
        issue(1, 4'h3, 1);
        drain("stall_drain");
        ar_delay = 0; r_delay = 0;

        // upstream backpressure on port 1 while port 3 waits
        tick();
        s_ul_rready = 4'b1101;
        issue(1, 4'h6, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ul_arready[1] && n < 50);
        if (n >= 50) fail("bp_grant1_timeout", n);
        issue(3, 4'h7, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ul_rvalid[1] && n < 50);
        if (n >= 50) fail("bp_rvalid_timeout", n);
        for (int i = 0; i < 6; i++) begin
            check("bp_no_arready3", 32'(s_ul_arready[3]), 0);
            check("bp_rvalid_held", 32'(s_ul_rvalid), 32'h2);
            @(negedge clk);
        end
        tick();
        s_ul_rready = 4'b1111;
        drain("bp_drain");

        // spurious downstream valid and non-granted rready
        tick();
        slave_en = 1'b0;
        s_ul_rready = 4'b1110;
        man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF;
        tick(); tick();
        man_rvalid = 1'b0;
        @(negedge clk);
        check("spur_idle_rvalid", 32'(s_ul_rvalid), 0);
        check("spur_idle_busy", 32'(busy), 0);
        issue(0, 4'h2, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_ul_arvalid && n < 50);
        if (n >= 50) fail("spur_addr_timeout", n);
        tick();
        man_rvalid = 1'b1;
        tick();
        @(negedge clk);
        check("spur_addr_rvalid", 32'(s_ul_rvalid), 0);
        check("spur_addr_arvalid", 32'(m_ul_arvalid), 1);
        check("spur_addr_m_rready", 32'(m_ul_rready), 0);
        tick();
        man_rvalid = 1'b0; man_arready = 1'b1;
        tick();
        man_arready = 1'b0; man_rvalid = 1'b1; man_rdata = data_tbl[2];
        tick();
        man_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_resp_held", 32'(s_ul_rvalid), 32'h1);
        end
        tick();
        s_ul_rready = 4'b1111;
        drain("spur_drain");

        // reset while in ST_DATA
        issue(2, 4'h4, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_ul_arvalid && n < 50);
        if (n >= 50) fail("rst_addr_timeout", n);
        tick();
        man_arready = 1'b1;
        tick();
        man_arready = 1'b0;
        @(negedge clk);
        check("mid_data_m_rready", 32'(m_ul_rready), 1);
        tick();
        s_ul_areset = 1'b1;
        tick();
        s_ul_areset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        check("mid_rst_s_rvalid", 32'(s_ul_rvalid), 0);
        check("mid_rst_m_arvalid", 32'(m_ul_arvalid), 0);
        check("mid_rst_m_rready", 32'(m_ul_rready), 0);
        check("mid_rst_s_arready", 32'(s_ul_arready), 0);
        slave_en = 1'b1;
        issue(0, 4'hD, 1); issue(1, 4'hE, 1);
        drain("post_rst_drain");

        repeat (3) @(negedge clk);
        check("end_resp_queue", exp_q.size(), 0);
        check("end_grant_queue", exp_grant_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
